// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone memory arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    typedef enum logic {
        MST0 = 1'b0,
        MST1 = 1'b1
    } mst_e;

    localparam logic [1:0]  GNT_NONE   = 2'b00;
    localparam logic [1:0]  GNT_M0     = 2'b01;
    localparam logic [1:0]  GNT_M1     = 2'b10;
    localparam logic [15:0] TO_RD_DATA = 16'hFFFF;

endpackage

// File: rtl/wb_arb_wdog.sv
// Grant watchdog: counts grant cycles without a slave ack and flags expiry.
module wb_arb_wdog #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    // The counter holds completed grant cycles, so the TIMEOUT-th cycle reads TIMEOUT-1.
    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the shared memory controller,
// with a per-transfer ack watchdog.
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [19:0] m0_adr_i,
    input  logic [19:0] m1_adr_i,
    input  logic [15:0] m0_dat_i,
    input  logic [15:0] m1_dat_i,
    output logic [15:0] m0_dat_o,
    output logic [15:0] m1_dat_o,
    input  logic        m0_we_i,
    input  logic        m1_we_i,
    input  logic        m0_byte_i,
    input  logic        m1_byte_i,
    input  logic        m0_stb_i,
    input  logic        m1_stb_i,
    output logic        m0_ack_o,
    output logic        m1_ack_o,
    output logic [19:0] s_adr_o,
    output logic [15:0] s_dat_o,
    input  logic [15:0] s_dat_i,
    output logic        s_we_o,
    output logic        s_byte_o,
    output logic        s_stb_o,
    input  logic        s_ack_i,
    output logic [1:0]  gnt_o,
    output logic        to_flag_o
);

    arb_state_e state_q, state_d;
    mst_e       last_q;
    logic [1:0] gnt_q, gnt_d;
    logic       to_flag_q;
    logic       expire;
    logic       to_fire;

    wb_arb_wdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (state_q == IDLE),
        .inc_i    ((state_q != IDLE) && !s_ack_i),
        .expire_o (expire)
    );

    always_comb begin
        state_d  = state_q;
        to_fire  = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_byte_o = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_dat_o = '0;

        case (state_q)
            IDLE: begin
                if (m0_stb_i && m1_stb_i) begin
                    state_d = (last_q == MST0) ? GNT1 : GNT0;
                end else if (m0_stb_i) begin
                    state_d = GNT0;
                end else if (m1_stb_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                // A real ack beats a coincident expiry; an abort beats both.
                to_fire  = expire && m0_stb_i && !s_ack_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_byte_o = m0_byte_i;
                s_stb_o  = m0_stb_i && !to_fire;
                m0_ack_o = s_ack_i || to_fire;
                m0_dat_o = to_fire ? TO_RD_DATA : s_dat_i;
                if (s_ack_i || !m0_stb_i || to_fire) begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                to_fire  = expire && m1_stb_i && !s_ack_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_byte_o = m1_byte_i;
                s_stb_o  = m1_stb_i && !to_fire;
                m1_ack_o = s_ack_i || to_fire;
                m1_dat_o = to_fire ? TO_RD_DATA : s_dat_i;
                if (s_ack_i || !m1_stb_i || to_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (state_d)
            GNT0:    gnt_d = GNT_M0;
            GNT1:    gnt_d = GNT_M1;
            default: gnt_d = GNT_NONE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            last_q    <= MST1;
            gnt_q     <= GNT_NONE;
            to_flag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            if (state_q == IDLE && state_d == GNT0) begin
                last_q <= MST0;
            end else if (state_q == IDLE && state_d == GNT1) begin
                last_q <= MST1;
            end
            if (to_fire) begin
                to_flag_q <= 1'b1;
            end
        end
    end

    assign gnt_o     = gnt_q;
    assign to_flag_o = to_flag_q;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: stimulus queues expected acks, a negedge monitor checks them.
module tb_wb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [19:0] m0_adr_i, m1_adr_i;
    logic [15:0] m0_dat_i, m1_dat_i;
    logic [15:0] m0_dat_o, m1_dat_o;
    logic        m0_we_i, m1_we_i, m0_byte_i, m1_byte_i, m0_stb_i, m1_stb_i;
    logic        m0_ack_o, m1_ack_o;
    logic [19:0] s_adr_o;
    logic [15:0] s_dat_o, s_dat_i;
    logic        s_we_o, s_byte_o, s_stb_o, s_ack_i;
    logic [1:0]  gnt_o;
    logic        to_flag_o;

    always #5 clk = ~clk;

    wb_mem_arbiter #(.TIMEOUT(4), .TO_W(8)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .m0_adr_i  (m0_adr_i),
        .m1_adr_i  (m1_adr_i),
        .m0_dat_i  (m0_dat_i),
        .m1_dat_i  (m1_dat_i),
        .m0_dat_o  (m0_dat_o),
        .m1_dat_o  (m1_dat_o),
        .m0_we_i   (m0_we_i),
        .m1_we_i   (m1_we_i),
        .m0_byte_i (m0_byte_i),
        .m1_byte_i (m1_byte_i),
        .m0_stb_i  (m0_stb_i),
        .m1_stb_i  (m1_stb_i),
        .m0_ack_o  (m0_ack_o),
        .m1_ack_o  (m1_ack_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_dat_i   (s_dat_i),
        .s_we_o    (s_we_o),
        .s_byte_o  (s_byte_o),
        .s_stb_o   (s_stb_o),
        .s_ack_i   (s_ack_i),
        .gnt_o     (gnt_o),
        .to_flag_o (to_flag_o)
    );

    typedef struct {
        logic        m;
        logic [15:0] dat;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic ack_pending = 1'b0;
    logic        got_m;
    logic [15:0] got_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Every expected ack must have been consumed by the monitor within its cycle.
    task automatic step();
        @(posedge clk);
        #1;
        s_ack_i = 1'b0;
        if (ack_pending) begin
            chk("ack_missing", 32'(exp_q.size()), 32'd0);
            ack_pending = 1'b0;
        end
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic expect_ack(input logic m, input logic [15:0] d);
        exp_t e;
        e.m   = m;
        e.dat = d;
        exp_q.push_back(e);
        ack_pending = 1'b1;
    endtask

    task automatic ack_now(input logic m, input logic [15:0] d);
        s_ack_i = 1'b1;
        s_dat_i = d;
        expect_ack(m, d);
    endtask

    always @(negedge clk) begin
        if (!rst_i && (m0_ack_o || m1_ack_o)) begin
            n_tests++;
            if (m0_ack_o && m1_ack_o) begin
                n_fail++;
                $display("FAIL ack_both: got m0_ack=1 m1_ack=1, expected only one");
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL ack_unexpected: got ack m%0d dat=0x%0h, expected no ack",
                         m1_ack_o, m1_ack_o ? m1_dat_o : m0_dat_o);
            end else begin
                exp_e = exp_q.pop_front();
                got_m = m1_ack_o;
                got_d = m1_ack_o ? m1_dat_o : m0_dat_o;
                if (got_m !== exp_e.m || got_d !== exp_e.dat) begin
                    n_fail++;
                    $display("FAIL ack_data: got m%0d dat=0x%0h, expected m%0d dat=0x%0h",
                             got_m, got_d, exp_e.m, exp_e.dat);
                end
            end
        end
    end

    initial begin
        rst_i = 1'b1;
        m0_adr_i = '0; m1_adr_i = '0; m0_dat_i = '0; m1_dat_i = '0;
        m0_we_i = 1'b0; m1_we_i = 1'b0; m0_byte_i = 1'b0; m1_byte_i = 1'b0;
        m0_stb_i = 1'b0; m1_stb_i = 1'b0; s_dat_i = '0; s_ack_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        neg();
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_stb", 32'(s_stb_o), 32'd0);
        chk("rst_flag", 32'(to_flag_o), 32'd0);
        chk("rst_acks", 32'({m0_ack_o, m1_ack_o}), 32'd0);
        chk("rst_adr", 32'(s_adr_o), 32'd0);

        // Single m0 read, slave acks in the third grant cycle
        m0_stb_i = 1'b1; m0_adr_i = 20'h12345;
        step(); neg();
        chk("rd_gnt", 32'(gnt_o), 32'd1);
        chk("rd_stb", 32'(s_stb_o), 32'd1);
        chk("rd_adr", 32'(s_adr_o), 32'h12345);
        chk("rd_we", 32'(s_we_o), 32'd0);
        step();
        step(); ack_now(1'b0, 16'h1234); neg();
        step(); m0_stb_i = 1'b0; neg();
        chk("rd_idle_gnt", 32'(gnt_o), 32'd0);
        chk("rd_idle_stb", 32'(s_stb_o), 32'd0);
        chk("rd_idle_dat", 32'(m0_dat_o), 32'd0);

        // Contention straight after reset: m0, m1, m0
        rst_i = 1'b1; step(); rst_i = 1'b0;
        m0_stb_i = 1'b1; m1_stb_i = 1'b1;
        m0_adr_i = 20'h0A000; m1_adr_i = 20'h0B000;
        m1_we_i = 1'b1; m1_byte_i = 1'b1; m1_dat_i = 16'hBEEF;
        step(); ack_now(1'b0, 16'h1111); neg();
        chk("cont_g1", 32'(gnt_o), 32'd1);
        chk("cont_g1_adr", 32'(s_adr_o), 32'h0A000);
        step(); neg();
        chk("cont_idle", 32'(gnt_o), 32'd0);
        step(); ack_now(1'b1, 16'h2222); neg();
        chk("cont_g2", 32'(gnt_o), 32'd2);
        chk("cont_g2_adr", 32'(s_adr_o), 32'h0B000);
        chk("cont_g2_we", 32'(s_we_o), 32'd1);
        chk("cont_g2_byte", 32'(s_byte_o), 32'd1);
        chk("cont_g2_wdat", 32'(s_dat_o), 32'hBEEF);
        step(); step(); ack_now(1'b0, 16'h3333); neg();
        chk("cont_g3", 32'(gnt_o), 32'd1);
        step(); m0_stb_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_byte_i = 1'b0; neg();
        chk("cont_end", 32'(gnt_o), 32'd0);

        // m1 aborts before any ack
        m1_stb_i = 1'b1;
        step(); neg();
        chk("abort_gnt", 32'(gnt_o), 32'd2);
        chk("abort_stb", 32'(s_stb_o), 32'd1);
        step(); m1_stb_i = 1'b0; neg();
        step(); neg();
        chk("abort_idle", 32'(gnt_o), 32'd0);
        chk("abort_stb_low", 32'(s_stb_o), 32'd0);

        // Watchdog expiry on the 4th grant cycle, then a normal transfer
        m0_stb_i = 1'b1; m0_adr_i = 20'h00077;
        step(); step();
        step(); neg();
        chk("wd_c3_stb", 32'(s_stb_o), 32'd1);
        chk("wd_c3_flag", 32'(to_flag_o), 32'd0);
        step(); expect_ack(1'b0, 16'hFFFF); neg();
        chk("wd_stb_low", 32'(s_stb_o), 32'd0);
        chk("wd_flag_pre", 32'(to_flag_o), 32'd0);
        step(); m0_stb_i = 1'b0; neg();
        chk("wd_flag_set", 32'(to_flag_o), 32'd1);
        chk("wd_idle", 32'(gnt_o), 32'd0);
        m0_stb_i = 1'b1; m0_adr_i = 20'h00078;
        step(); ack_now(1'b0, 16'h5A5A); neg();
        chk("wd_next_gnt", 32'(gnt_o), 32'd1);
        chk("wd_flag_sticky", 32'(to_flag_o), 32'd1);
        step(); m0_stb_i = 1'b0;

        // Ack in the same cycle as expiry: real data, no flag
        rst_i = 1'b1; step(); rst_i = 1'b0; neg();
        chk("rst_flag_clr", 32'(to_flag_o), 32'd0);
        m1_stb_i = 1'b1; m1_adr_i = 20'h00099;
        step(); step(); step();
        step(); ack_now(1'b1, 16'h00A5); neg();
        step(); m1_stb_i = 1'b0; neg();
        chk("coinc_flag", 32'(to_flag_o), 32'd0);
        chk("coinc_idle", 32'(gnt_o), 32'd0);

        // Reset during GNT1, then contention restarts with m0
        m1_stb_i = 1'b1;
        step(); neg();
        chk("rstmid_gnt1", 32'(gnt_o), 32'd2);
        rst_i = 1'b1; m0_stb_i = 1'b1;
        step(); rst_i = 1'b0; neg();
        chk("rstmid_gnt", 32'(gnt_o), 32'd0);
        chk("rstmid_stb", 32'(s_stb_o), 32'd0);
        chk("rstmid_ack", 32'(m1_ack_o), 32'd0);
        step(); ack_now(1'b0, 16'hC0DE); neg();
        chk("rstmid_m0_first", 32'(gnt_o), 32'd1);
        step(); m0_stb_i = 1'b0; m1_stb_i = 1'b0; neg();

        chk("acks_outstanding", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_mem_arbiter.md
# wb_mem_arbiter

Two-master Wishbone arbiter that shares the single SRAM/Flash controller port between the CPU and a second requester (video refresh / DMA). It sits between the masters and the memory map decode, grants one master at a time with round-robin fairness, and forwards that master's cycle to the memory controller. A per-cycle watchdog terminates any transfer whose slave acknowledge never arrives.

## Interface
Parameters:
- TIMEOUT, 255: cycles in a grant state without `s_ack_i` before forced termination (1..2^TO_W-1).
- TO_W, 8: width of the watchdog counter.

Ports:
- clk_i  in  1  system clock; all state on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- m0_adr_i, m1_adr_i  in  20  master address.
- m0_dat_i, m1_dat_i  in  16  master write data.
- m0_dat_o, m1_dat_o  out  16  read data to master.
- m0_we_i, m1_we_i  in  1  write enable.
- m0_byte_i, m1_byte_i  in  1  byte transfer.
- m0_stb_i, m1_stb_i  in  1  cycle request.
- m0_ack_o, m1_ack_o  out  1  cycle acknowledge.
- s_adr_o  out  20  address to memory controller.
- s_dat_o  out  16  write data to memory controller.
- s_dat_i  in  16  read data from memory controller.
- s_we_o, s_byte_o, s_stb_o  out  1  forwarded controls.
- s_ack_i  in  1  slave acknowledge, single-cycle pulse.
- gnt_o  out  2  one-hot current grant (bit0 = m0, bit1 = m1).
- to_flag_o  out  1  sticky watchdog-fired flag.

## Operation
- States: IDLE, GNT0, GNT1.
- IDLE: no stb → stay. Only one master's stb → go to that master's GNT. Both → grant the master *not* granted last (`last` pointer); `last` updates on every grant.
- GNTx: `s_adr_o`, `s_dat_o`, `s_we_o`, `s_byte_o` and `s_stb_o` are driven combinationally from master x. `mx_ack_o = s_ack_i`, `mx_dat_o = s_dat_i`. The other master's ack is 0.
- Leaving GNTx: `s_ack_i`=1 → IDLE. `mx_stb_i` dropped before ack (abort) → IDLE with no ack. Watchdog expiry → IDLE.
- Watchdog: counter cleared on entering GNTx, increments each GNT cycle without ack. On the cycle it equals TIMEOUT:
  - `mx_ack_o`=1 and `mx_dat_o`=16'hFFFF;
  - `s_stb_o`=0;
  - `to_flag_o` set (cleared only by reset).
- Inactive outputs: in IDLE, `s_stb_o`=0, both acks 0, `s_*` data/address outputs 0, `m*_dat_o` 0.
- Reset values: state IDLE, `gnt_o`=00, `to_flag_o`=0, `last`=m1 (so m0 wins the first contention), counter 0, all acks and `s_stb_o` 0.

## Timing
- Request latency: stb sampled high in IDLE at cycle n → GNT at n+1 → `s_stb_o` high at n+1.
- Best-case transfer with 1-cycle slave: stb at n, ack at n+1.
- One mandatory IDLE cycle after every ack, abort or timeout, so back-to-back requests from the same master are accepted every 2 slave-ack cycles minimum.
- Simultaneous ack and watchdog expiry in the same cycle: the real ack wins. Data is `s_dat_i` and `to_flag_o` is not set.
- Simultaneous ack and stb drop: treated as a completed ack.
- `rst_i` mid-transfer: the next cycle is IDLE with all outputs at reset values. The in-flight master receives no ack.
- `gnt_o` is registered; it is 00 in IDLE.

## Structure
- Shared package `wb_arb_pkg` holds:
  - state enum (IDLE/GNT0/GNT1);
  - grant encoding constants;
  - the timeout read pattern 16'hFFFF.
- Optional sub-module `wb_arb_wdog`: TO_W-bit clear/increment counter with an expiry compare. Everything else stays flat in `wb_arb_pkg`'s user module.

## Test plan
- Single m0 read: m0 stb at cycle 0, slave acks at cycle 3 with 16'h1234 → m0 ack at 3, m0 dat 16'h1234, IDLE at 4, m1 ack never asserted.
- Contention: both stb from reset → m0 granted first. After m0's ack, m1 granted at the next IDLE→GNT1. With both still requesting, grants alternate m0, m1, m0.
- Abort: m1 granted, m1 drops stb at cycle 2 before any ack → IDLE at 3, no ack, `s_stb_o` low at 3.
- Watchdog: TIMEOUT=4, slave never acks → ack with 16'hFFFF at the 4th GNT cycle, `to_flag_o`=1 thereafter, next request is served normally.
- Ack coincident with timeout, with slave data 16'h00A5 → master gets 16'h00A5 and `to_flag_o` stays 0.
- `rst_i` asserted during GNT1 → `gnt_o`=00, `s_stb_o`=0 next cycle. Subsequent contention grants m0 first.
